alu_datapath: RTL
=================

ALU_DATAPATH -- requirements
Module: ALU_Datapath

Interface
REQ-001 The block SHALL use these ports: Clock, input, 1, the single system clock (all state on rising edge).
REQ-002 Reset, input, 1: synchronous, active-high reset.
REQ-003 AluClock, input, 1: single-cycle operation strobe, sampled on Clock.
REQ-004 AluActive, input, 1: flag-write enable, qualifies AluClock.
REQ-005 AC0_RHS0..AC3_RHS3, input, 1 each: RHS mode, bits 0..3.
REQ-006 AC4_LHS0..AC5_LHS1, input, 1 each: LHS mode, bits 0..1.
REQ-007 AC6_CS0..AC7_CS1, input, 1 each: carry-select, bits 0..1.
REQ-008 Lhs, input, 8: left operand.
REQ-009 Rhs, input, 8: right operand.
REQ-010 AluResult, output, 8: last registered result.
REQ-011 FlagC, FlagZ, FlagS, FlagO, output, 1 each: carry, zero, sign, signed overflow.
REQ-012 ResultValid, output, 1: one-cycle pulse when AluResult updates.

Function
REQ-013 Stage A SHALL capture Lhs, Rhs, AC0..AC7 and AluActive, and set a valid bit, on each Clock edge where AluClock=1; otherwise its valid bit SHALL clear.
REQ-014 Stage B SHALL compute from the stage-A registers and update AluResult, the flags and ResultValid on the next edge.
- Latency: strobe at edge N gives results at edge N+1.
- Full throughput: one operation per cycle.
REQ-015 RHS mode decode (Rsel):
- 0 -> 0x00; 1 -> Rhs; 2 -> ~Rhs; 3 -> 0xFF.
- 4 -> Lhs&Rhs; 5 -> Lhs|Rhs; 6 -> Lhs^Rhs; 7 -> ~(Lhs&Rhs).
- 8-15 reserved -> 0x00.
REQ-016 LHS mode decode (Lsel):
- 0 -> Lhs; 1 -> 0x00.
- 2 -> Lhs>>1, logical, with the shifted-out bit used as carry-out.
- 3 -> {Lhs[6:0],0}, with Lhs[7] used as carry-out.
REQ-017 Carry-in select: 0 -> 0; 1 -> 1; 2 -> FlagC; 3 -> ~FlagC.
- FlagC is the registered value at the stage-B cycle, so back-to-back carry chains need no stall.
REQ-018 Sum arithmetic:
- Sum = Lsel + Rsel + cin, computed at 9 bits.
- AluResult = Sum[7:0].
REQ-019 Flag computation:
- FlagC = Sum[8] for LHS modes 0/1; the shift-out bit for modes 2/3.
- FlagZ = (Sum[7:0]==0).
- FlagS = Sum[7].
- FlagO = (Lsel[7]==Rsel[7]) && (Sum[7]!=Lsel[7]).
REQ-020 Flags SHALL update only when the captured AluActive=1; otherwise they hold, while AluResult and ResultValid still update.
REQ-021 With no valid stage-A entry, AluResult and the flags SHALL hold and ResultValid SHALL be 0.
REQ-022 ResultValid SHALL be high for exactly one cycle per accepted strobe; consecutive strobes give consecutive pulses.
REQ-023 Control or operand changes on cycles without AluClock SHALL have no effect.

Reset
REQ-024 While Reset=1 at an edge, the block SHALL clear:
- AluResult=0x00; FlagC, FlagZ, FlagS, FlagO=0; ResultValid=0.
- the stage-A registers and valid bit.
REQ-025 Reset SHALL override a simultaneous AluClock strobe, and an operation in flight SHALL be discarded with no ResultValid pulse.
REQ-026 The first strobe accepted at the edge after Reset deasserts SHALL complete normally.

Verification
REQ-027 Add overflow:
- Stimulus: Lhs=0x7F, Rhs=0x01, RHS=1, LHS=0, CS=0, AluActive=1, strobe at edge N.
- Response at N+1: AluResult=0x80, C=0 Z=0 S=1 O=1, ResultValid high 1 cycle.
REQ-028 Subtract equal:
- Stimulus: Lhs=0x05, Rhs=0x05, RHS=2, CS=1.
- Response: AluResult=0x00, C=1 Z=1 S=0 O=0.
REQ-029 Carry chain, back-to-back:
- Stimulus: 0xFF+0x01 (CS=0) at edge N, then 0x00+0x00 (CS=2) at edge N+1.
- Response: results 0x00 (C=1), then 0x01 (C=0); ResultValid high at N+1 and N+2.
REQ-030 Flag hold:
- Stimulus: after REQ-027, Lhs=0x00, Rhs=0x00, RHS=1, AluActive=0.
- Response: AluResult=0x00; flags remain C=0 Z=0 S=1 O=1.
REQ-031 Reset mid-operation:
- Stimulus: strobe at edge N, Reset=1 at edge N+1.
- Response: no ResultValid pulse; all outputs 0.
REQ-032 Reserved mode and shift:
- Stimulus A: RHS=9, Lhs=0x10, LHS=0, CS=0.
- Response A: AluResult=0x10.
- Stimulus B: LHS=3, Lhs=0x81, RHS=0.
- Response B: AluResult=0x02, FlagC=1.

Source files
------------

// File: rtl/alu_datapath.sv
// ---------------------------------------------------------------------------
// alu_datapath
//
// Two-stage 8-bit ALU datapath with a registered flag file.
//
// Stage A captures the operands and the control word on every Clock edge
// where the AluClock strobe is high, and marks itself valid. Stage B turns a
// valid stage-A entry into a result and flags on the following edge. With one
// strobe per cycle, one result is produced per cycle.
//
// Ports
//   Clock         in   1  system clock, all state on the rising edge
//   Reset         in   1  synchronous, active-high reset
//   AluClock      in   1  operation strobe
//   AluActive     in   1  flag-write enable for the strobed operation
//   AC0_RHS0..3   in   1  right-hand operand mode, bits 0..3
//   AC4_LHS0..1   in   1  left-hand operand mode, bits 0..1
//   AC6_CS0..1    in   1  carry-in select, bits 0..1
//   Lhs           in   8  left operand
//   Rhs           in   8  right operand
//   AluResult     out  8  last registered result
//   FlagC/Z/S/O   out  1  carry, zero, sign, signed overflow
//   ResultValid   out  1  one-cycle pulse on each AluResult update
//
// Valid semantics: a strobe seen at edge N always produces exactly one
// ResultValid pulse after edge N+1, unless Reset is high at edge N or N+1.
// There is no back-pressure; the datapath never stalls.
// ---------------------------------------------------------------------------
module alu_datapath (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       AluClock,
  input  logic       AluActive,
  input  logic       AC0_RHS0,
  input  logic       AC1_RHS1,
  input  logic       AC2_RHS2,
  input  logic       AC3_RHS3,
  input  logic       AC4_LHS0,
  input  logic       AC5_LHS1,
  input  logic       AC6_CS0,
  input  logic       AC7_CS1,
  input  logic [7:0] Lhs,
  input  logic [7:0] Rhs,
  output logic [7:0] AluResult,
  output logic       FlagC,
  output logic       FlagZ,
  output logic       FlagS,
  output logic       FlagO,
  output logic       ResultValid
);

  // Stage A registers
  logic       a_valid_q,  a_valid_d;
  logic       a_active_q, a_active_d;
  logic [7:0] a_lhs_q,    a_lhs_d;
  logic [7:0] a_rhs_q,    a_rhs_d;
  logic [3:0] a_rmode_q,  a_rmode_d;
  logic [1:0] a_lmode_q,  a_lmode_d;
  logic [1:0] a_cs_q,     a_cs_d;

  // Stage B / output registers
  logic [7:0] result_q,   result_d;
  logic       flag_c_q,   flag_c_d;
  logic       flag_z_q,   flag_z_d;
  logic       flag_s_q,   flag_s_d;
  logic       flag_o_q,   flag_o_d;
  logic       res_valid_q, res_valid_d;

  // Stage B combinational datapath
  logic [7:0] rsel;
  logic [7:0] lsel;
  logic       shift_out;
  logic       cin;
  logic [8:0] sum;
  logic       carry_out;

  // Stage A capture: operands and controls only move on a strobe, so
  // activity on those inputs between strobes is invisible downstream.
  always_comb begin
    a_valid_d  = AluClock;
    a_active_d = a_active_q;
    a_lhs_d    = a_lhs_q;
    a_rhs_d    = a_rhs_q;
    a_rmode_d  = a_rmode_q;
    a_lmode_d  = a_lmode_q;
    a_cs_d     = a_cs_q;
    if (AluClock) begin
      a_active_d = AluActive;
      a_lhs_d    = Lhs;
      a_rhs_d    = Rhs;
      a_rmode_d  = {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0};
      a_lmode_d  = {AC5_LHS1, AC4_LHS0};
      a_cs_d     = {AC7_CS1, AC6_CS0};
    end
  end

  // Right-hand operand decode; codes 8..15 are reserved and yield zero.
  always_comb begin
    rsel = 8'h00;
    case (a_rmode_q)
      4'd0:    rsel = 8'h00;
      4'd1:    rsel = a_rhs_q;
      4'd2:    rsel = ~a_rhs_q;
      4'd3:    rsel = 8'hFF;
      4'd4:    rsel = a_lhs_q & a_rhs_q;
      4'd5:    rsel = a_lhs_q | a_rhs_q;
      4'd6:    rsel = a_lhs_q ^ a_rhs_q;
      4'd7:    rsel = ~(a_lhs_q & a_rhs_q);
      default: rsel = 8'h00;
    endcase
  end

  // Left-hand operand decode; the shift modes also produce the bit that
  // replaces the adder carry as the carry flag.
  always_comb begin
    lsel      = a_lhs_q;
    shift_out = 1'b0;
    case (a_lmode_q)
      2'd0: lsel = a_lhs_q;
      2'd1: lsel = 8'h00;
      2'd2: begin
        lsel      = {1'b0, a_lhs_q[7:1]};
        shift_out = a_lhs_q[0];
      end
      default: begin
        lsel      = {a_lhs_q[6:0], 1'b0};
        shift_out = a_lhs_q[7];
      end
    endcase
  end

  // Carry-in uses the flag register as it stands in the stage-B cycle, so
  // an operation strobed right behind a flag-writing one sees its carry.
  always_comb begin
    cin = 1'b0;
    case (a_cs_q)
      2'd0:    cin = 1'b0;
      2'd1:    cin = 1'b1;
      2'd2:    cin = flag_c_q;
      default: cin = ~flag_c_q;
    endcase
  end

  always_comb begin
    sum       = {1'b0, lsel} + {1'b0, rsel} + {8'h00, cin};
    carry_out = a_lmode_q[1] ? shift_out : sum[8];
  end

  // Stage B update: result and valid follow every stage-A entry, flags only
  // when that entry was captured with AluActive set.
  always_comb begin
    result_d    = result_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    flag_s_d    = flag_s_q;
    flag_o_d    = flag_o_q;
    res_valid_d = 1'b0;
    if (a_valid_q) begin
      result_d    = sum[7:0];
      res_valid_d = 1'b1;
      if (a_active_q) begin
        flag_c_d = carry_out;
        flag_z_d = (sum[7:0] == 8'h00);
        flag_s_d = sum[7];
        flag_o_d = (lsel[7] == rsel[7]) && (sum[7] != lsel[7]);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_valid_q   <= 1'b0;
      a_active_q  <= 1'b0;
      a_lhs_q     <= 8'h00;
      a_rhs_q     <= 8'h00;
      a_rmode_q   <= 4'h0;
      a_lmode_q   <= 2'd0;
      a_cs_q      <= 2'd0;
      result_q    <= 8'h00;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_s_q    <= 1'b0;
      flag_o_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_active_q  <= a_active_d;
      a_lhs_q     <= a_lhs_d;
      a_rhs_q     <= a_rhs_d;
      a_rmode_q   <= a_rmode_d;
      a_lmode_q   <= a_lmode_d;
      a_cs_q      <= a_cs_d;
      result_q    <= result_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_s_q    <= flag_s_d;
      flag_o_q    <= flag_o_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign AluResult   = result_q;
  assign FlagC       = flag_c_q;
  assign FlagZ       = flag_z_q;
  assign FlagS       = flag_s_q;
  assign FlagO       = flag_o_q;
  assign ResultValid = res_valid_q;

endmodule
